uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a small transmit FIFO in front of it.
//
// Words pushed through wr_en/wr_data are queued in a FIFO_DEPTH-entry FIFO.
// The frame engine pops one word at a time and serialises it as
// start bit, DATA_LEN data bits (LSB first), optional parity bit and
// STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clock cycles.
// Queued words are sent back-to-back with no idle bit between frames.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   wr_en      in   push request for wr_data
//   wr_data    in   word to transmit (DATA_LEN bits)
//   wr_ready   out  FIFO not full (registered full flag only)
//   tx_data    out  serial line, idle high
//   tx_busy    out  frame engine not idle
//   tx_done    out  one-cycle pulse per completed frame
//   fifo_count out  words currently queued
//   overflow   out  one-cycle pulse after a write attempted while full
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int DATA_LEN     = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_LEN-1:0]           wr_data,
    output logic                          wr_ready,
    output logic                          tx_data,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_LEN);

    localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_LEN - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic          ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_LEN-1:0]  shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 done_q, done_d;

    logic [DATA_LEN-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q;
    logic                 overflow_q;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 bit_end;

    // Full is taken from the registered count only, so a pop in the same
    // cycle never frees a slot for a simultaneous push.
    assign full       = (count_q == FULL_CNT);
    assign push       = wr_en & ~full;
    assign bit_end    = (clk_cnt_q == LAST_CLK);

    assign wr_ready   = ~full;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign tx_done    = done_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        tx_data   = 1'b1;
        tx_busy   = 1'b1;

        case (state_q)
            S_IDLE: begin
                tx_busy = 1'b0;
                if (count_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    parity_d  = (^mem_q[rd_ptr_q]) ^ ODD_PAR;
                    clk_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                tx_data = 1'b0;
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                tx_data = shift_q[0];
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                tx_data = parity_q;
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                        // Back-to-back: load the next word straight into START.
                        if (count_q != '0) begin
                            pop      = 1'b1;
                            shift_d  = mem_q[rd_ptr_q];
                            parity_d = (^mem_q[rd_ptr_q]) ^ ODD_PAR;
                            state_d  = S_START;
                        end else begin
                            state_d  = S_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: begin
                tx_busy   = 1'b0;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            done_q     <= done_d;
            overflow_q <= wr_en & full;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
